// File: rtl/mont_accum_arbiter_if.sv
// Requester- and accumulator-facing signal bundle for mont_accum_arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface mont_accum_arbiter_if #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned REGISTER_SIZE = 32
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester side
    logic [NUM_REQ-1:0]               req_in;
    logic [NUM_REQ-1:0]               base_valid_in;
    logic [NUM_REQ*REGISTER_SIZE-1:0] base_block_in;
    logic [NUM_REQ-1:0]               base_ready_out;
    logic [NUM_REQ-1:0]               exp_bit_in;
    logic [NUM_REQ-1:0]               exp_ack_out;
    logic [NUM_REQ-1:0]               res_valid_out;
    logic [REGISTER_SIZE-1:0]         res_data_out;
    logic [IDX_W-1:0]                 grant_out;
    logic                             busy_out;
    logic                             error_out;

    // Accumulator side
    logic                             acc_rst_out;
    logic                             acc_valid_out;
    logic [REGISTER_SIZE-1:0]         acc_data_out;
    logic                             acc_n_bit_out;
    logic                             acc_consumed_n_in;
    logic                             acc_valid_in;
    logic [REGISTER_SIZE-1:0]         acc_data_in;

    modport slave (
        input  req_in, base_valid_in, base_block_in, exp_bit_in,
        input  acc_consumed_n_in, acc_valid_in, acc_data_in,
        output base_ready_out, exp_ack_out, res_valid_out, res_data_out,
        output grant_out, busy_out, error_out,
        output acc_rst_out, acc_valid_out, acc_data_out, acc_n_bit_out
    );

    modport master (
        output req_in, base_valid_in, base_block_in, exp_bit_in,
        output acc_consumed_n_in, acc_valid_in, acc_data_in,
        input  base_ready_out, exp_ack_out, res_valid_out, res_data_out,
        input  grant_out, busy_out, error_out,
        input  acc_rst_out, acc_valid_out, acc_data_out, acc_n_bit_out
    );
endinterface

// File: rtl/mont_accum_arbiter.sv
// Round-robin scheduler sharing one Montgomery accumulator among NUM_REQ requesters,
// with accumulator reset/init sequencing and a stall watchdog.
module mont_accum_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned REGISTER_SIZE   = 32,
    parameter int unsigned BITS_IN_NUM     = 4096,
    parameter int unsigned EXP_BITS        = 2048,
    parameter int unsigned ACC_INIT_CYCLES = 4,
    parameter int unsigned WATCHDOG_CYCLES = 65536
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    mont_accum_arbiter_if.slave bus
);
    localparam int unsigned BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BIT_W  = $clog2(EXP_BITS + 1);
    localparam int unsigned BLK_W  = $clog2(BLOCKS + 1);
    localparam int unsigned WD_W   = $clog2(WATCHDOG_CYCLES + 1);
    localparam int unsigned INIT_W = $clog2(ACC_INIT_CYCLES + 1);

    localparam logic [2:0] StAccRst  = 3'd0;
    localparam logic [2:0] StInit    = 3'd1;
    localparam logic [2:0] StIdle    = 3'd2;
    localparam logic [2:0] StRun     = 3'd3;
    localparam logic [2:0] StDrain   = 3'd4;
    localparam logic [2:0] StRelease = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [IDX_W-1:0]         g_q, g_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [BLK_W-1:0]         blk_cnt_q, blk_cnt_d;
    logic [WD_W-1:0]          wd_q, wd_d;
    logic [INIT_W-1:0]        init_q, init_d;
    logic                     err_q, err_d;

    logic                     pick_valid;
    logic [IDX_W-1:0]         pick_idx;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         next_g;
    logic [REGISTER_SIZE-1:0] sel_block;

    // Scan from the highest offset down so the lowest offset from rr_q wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((32'(rr_q) + 32'(i)) % NUM_REQ);
            if (bus.req_in[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    assign next_g = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);

    always_comb begin
        sel_block = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g_q == IDX_W'(i)) begin
                sel_block = bus.base_block_in[i*REGISTER_SIZE +: REGISTER_SIZE];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        rr_d      = rr_q;
        bit_cnt_d = bit_cnt_q;
        blk_cnt_d = blk_cnt_q;
        wd_d      = '0;
        init_d    = '0;
        err_d     = err_q;

        case (state_q)
            StAccRst: state_d = StInit;
            StInit: begin
                if (init_q == INIT_W'(ACC_INIT_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    init_d = init_q + INIT_W'(1);
                end
            end
            StIdle: begin
                bit_cnt_d = '0;
                blk_cnt_d = '0;
                if (pick_valid) begin
                    g_d     = pick_idx;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.acc_consumed_n_in) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(EXP_BITS - 1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (bus.acc_valid_in) begin
                    blk_cnt_d = blk_cnt_q + BLK_W'(1);
                    if (blk_cnt_q == BLK_W'(BLOCKS - 1)) begin
                        state_d = StRelease;
                    end
                end
            end
            StRelease: begin
                rr_d    = next_g;
                state_d = StIdle;
            end
            default: state_d = StAccRst;
        endcase

        // Any accumulator activity keeps the watchdog quiet; it is zero outside RUN/DRAIN,
        // so it always starts from zero on entry.
        if (state_q == StRun || state_q == StDrain) begin
            if (bus.acc_consumed_n_in || bus.acc_valid_in) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(WATCHDOG_CYCLES - 1)) begin
                err_d   = 1'b1;
                rr_d    = next_g;
                state_d = StAccRst;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= StAccRst;
            g_q       <= '0;
            rr_q      <= '0;
            bit_cnt_q <= '0;
            blk_cnt_q <= '0;
            wd_q      <= '0;
            init_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            rr_q      <= rr_d;
            bit_cnt_q <= bit_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            wd_q      <= wd_d;
            init_q    <= init_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        bus.base_ready_out = '0;
        bus.exp_ack_out    = '0;
        bus.res_valid_out  = '0;
        bus.res_data_out   = '0;
        bus.acc_valid_out  = 1'b0;
        bus.acc_data_out   = '0;
        bus.acc_n_bit_out  = 1'b0;
        case (state_q)
            StRun: begin
                bus.acc_valid_out      = bus.base_valid_in[g_q];
                bus.acc_data_out       = sel_block;
                bus.acc_n_bit_out      = bus.exp_bit_in[g_q];
                bus.base_ready_out[g_q] = 1'b1;
                bus.exp_ack_out[g_q]    = bus.acc_consumed_n_in;
            end
            StDrain: begin
                bus.res_valid_out[g_q] = bus.acc_valid_in;
                bus.res_data_out       = bus.acc_data_in;
            end
            default: ;
        endcase
    end

    assign bus.grant_out   = g_q;
    assign bus.busy_out    = (state_q == StRun) || (state_q == StDrain) || (state_q == StRelease);
    assign bus.error_out   = err_q;
    assign bus.acc_rst_out = (state_q == StAccRst);
endmodule

// File: tb/tb_mont_accum_arbiter.sv
// Directed bench for mont_accum_arbiter: round-robin order, routing, counts,
// watchdog abort and asynchronous reset mid-drain.
module tb_mont_accum_arbiter;
    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned RS       = 32;
    localparam int unsigned BITS     = 4096;
    localparam int unsigned EXP_BITS = 2048;
    localparam int unsigned BLOCKS   = 128;
    localparam int unsigned INIT_CYC = 4;
    localparam int unsigned WD_CYC   = 64;

    logic clk;
    logic rst_n;

    mont_accum_arbiter_if #(.NUM_REQ(NUM_REQ), .REGISTER_SIZE(RS)) bus ();

    mont_accum_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .REGISTER_SIZE  (RS),
        .BITS_IN_NUM    (BITS),
        .EXP_BITS       (EXP_BITS),
        .ACC_INIT_CYCLES(INIT_CYC),
        .WATCHDOG_CYCLES(WD_CYC)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_ack[NUM_REQ];
    int exp_res[NUM_REQ];
    int ack_cnt[NUM_REQ];
    int res_cnt[NUM_REQ];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sample mid-cycle, away from the active edge.
    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_cnt[i] = 0;
            res_cnt[i] = 0;
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.exp_ack_out[i])   ack_cnt[i] <= ack_cnt[i] + 1;
            if (bus.res_valid_out[i]) res_cnt[i] <= res_cnt[i] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20 && !bus.busy_out; i++) tick();
        check_eq("busy_wait", 32'(bus.busy_out), 32'd1);
    endtask

    task automatic check_totals(input string tag);
        for (int i = 0; i < NUM_REQ; i++) begin
            check_eq({tag, "_acks"}, 32'(ack_cnt[i]), 32'(exp_ack[i]));
            check_eq({tag, "_res"}, 32'(res_cnt[i]), 32'(exp_res[i]));
        end
    endtask

    task automatic drive_streams();
        bus.base_valid_in = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) bus.base_block_in[i*RS +: RS] = 32'hB000_00A0 | 32'(i);
        bus.exp_bit_in = 4'b0101;
    endtask

    // One full job on requester g; inject adds stray acc_valid_in in RUN and
    // stray acc_consumed_n_in in DRAIN.
    task automatic do_job(input int g, input logic [3:0] req_after, input bit inject);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        wait_busy();
        bus.req_in = req_after;
        check_eq("grant", 32'(bus.grant_out), 32'(g));
        check_eq("ready", 32'(bus.base_ready_out), 32'(oh));
        drive_streams();
        #1;
        check_eq("acc_valid", 32'(bus.acc_valid_out), 32'd1);
        check_eq("acc_data", bus.acc_data_out, 32'hB000_00A0 | 32'(g));
        check_eq("acc_nbit", 32'(bus.acc_n_bit_out), (g % 2 == 0) ? 32'd1 : 32'd0);
        check_eq("ack_idle", 32'(bus.exp_ack_out), 32'd0);
        bus.acc_consumed_n_in = 1'b1;
        if (inject) begin
            bus.acc_valid_in = 1'b1;
            bus.acc_data_in  = 32'hDEAD_0000;
        end
        #1;
        check_eq("ack_onehot", 32'(bus.exp_ack_out), 32'(oh));
        check_eq("res_in_run", 32'(bus.res_valid_out), 32'd0);
        for (int k = 0; k < EXP_BITS; k++) begin
            if (k == 5) bus.acc_valid_in = 1'b0;
            tick();
        end
        bus.acc_consumed_n_in = inject;
        bus.acc_valid_in      = 1'b1;
        bus.acc_data_in       = 32'hC0DE_0000 | 32'(g);
        #1;
        check_eq("drain_accv", 32'(bus.acc_valid_out), 32'd0);
        check_eq("drain_ready", 32'(bus.base_ready_out), 32'd0);
        check_eq("drain_ack", 32'(bus.exp_ack_out), 32'd0);
        check_eq("res_onehot", 32'(bus.res_valid_out), 32'(oh));
        check_eq("res_data", bus.res_data_out, 32'hC0DE_0000 | 32'(g));
        for (int b = 0; b < BLOCKS; b++) begin
            if (b == 3) bus.acc_consumed_n_in = 1'b0;
            tick();
        end
        check_eq("release_busy", 32'(bus.busy_out), 32'd1);
        check_eq("release_res", 32'(bus.res_valid_out), 32'd0);
        bus.acc_valid_in  = 1'b0;
        bus.base_valid_in = 4'h0;
        tick();
        check_eq("idle_busy", 32'(bus.busy_out), 32'd0);
        exp_ack[g] += EXP_BITS;
        exp_res[g] += BLOCKS;
        check_totals("job");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            exp_ack[i] = 0;
            exp_res[i] = 0;
        end
        rst_n                 = 1'b0;
        bus.req_in            = '0;
        bus.base_valid_in     = '0;
        bus.base_block_in     = '0;
        bus.exp_bit_in        = '0;
        bus.acc_consumed_n_in = 1'b0;
        bus.acc_valid_in      = 1'b0;
        bus.acc_data_in       = '0;

        repeat (2) tick();
        check_eq("rst_accrst", 32'(bus.acc_rst_out), 32'd1);
        check_eq("rst_busy", 32'(bus.busy_out), 32'd0);
        check_eq("rst_grant", 32'(bus.grant_out), 32'd0);
        check_eq("rst_error", 32'(bus.error_out), 32'd0);
        check_eq("rst_ready", 32'(bus.base_ready_out), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("init_accrst", 32'(bus.acc_rst_out), 32'd0);
        bus.req_in = 4'b1111;
        repeat (INIT_CYC) tick();
        check_eq("init_busy", 32'(bus.busy_out), 32'd0);
        tick();
        check_eq("first_grant_busy", 32'(bus.busy_out), 32'd1);

        // All requesting: strict round-robin 0,1,2,3,0
        do_job(0, 4'b1111, 1'b0);
        do_job(1, 4'b1111, 1'b0);
        do_job(2, 4'b1111, 1'b0);
        do_job(3, 4'b1111, 1'b0);
        do_job(0, 4'b0000, 1'b0);

        // Single request from IDLE is granted on the very next edge
        bus.req_in = 4'b0010;
        tick();
        check_eq("grant_latency", 32'(bus.busy_out), 32'd1);
        do_job(1, 4'b0000, 1'b0);

        // After job on 1: 1010 grants 3 then 1, requester 0 untouched
        bus.req_in = 4'b1010;
        do_job(3, 4'b1010, 1'b0);
        do_job(1, 4'b0000, 1'b0);

        bus.req_in = 4'b0100;
        do_job(2, 4'b0000, 1'b0);

        bus.req_in = 4'b0001;
        do_job(0, 4'b0000, 1'b1);

        // Watchdog: requester 1 granted, accumulator stalls
        bus.req_in = 4'b0010;
        wait_busy();
        bus.req_in = 4'b0000;
        check_eq("wd_grant", 32'(bus.grant_out), 32'd1);
        repeat (WD_CYC - 1) tick();
        check_eq("wd_err_early", 32'(bus.error_out), 32'd0);
        check_eq("wd_busy_early", 32'(bus.busy_out), 32'd1);
        tick();
        check_eq("wd_err", 32'(bus.error_out), 32'd1);
        check_eq("wd_accrst", 32'(bus.acc_rst_out), 32'd1);
        check_eq("wd_busy", 32'(bus.busy_out), 32'd0);
        bus.req_in = 4'b0011;
        tick();
        check_eq("wd_accrst_once", 32'(bus.acc_rst_out), 32'd0);
        repeat (INIT_CYC) tick();
        check_eq("wd_init_busy", 32'(bus.busy_out), 32'd0);
        check_eq("wd_accrst_low", 32'(bus.acc_rst_out), 32'd0);
        tick();
        check_eq("wd_regrant_busy", 32'(bus.busy_out), 32'd1);
        check_eq("wd_skip_grant", 32'(bus.grant_out), 32'd0);
        check_eq("wd_err_sticky", 32'(bus.error_out), 32'd1);
        check_totals("wd");

        // Job on 0, then asynchronous reset in the middle of DRAIN
        bus.req_in = 4'b0000;
        drive_streams();
        bus.acc_consumed_n_in = 1'b1;
        repeat (EXP_BITS) tick();
        bus.acc_consumed_n_in = 1'b0;
        bus.acc_valid_in      = 1'b1;
        bus.acc_data_in       = 32'h5A5A_0001;
        repeat (10) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_accrst", 32'(bus.acc_rst_out), 32'd1);
        check_eq("arst_busy", 32'(bus.busy_out), 32'd0);
        check_eq("arst_grant", 32'(bus.grant_out), 32'd0);
        check_eq("arst_error", 32'(bus.error_out), 32'd0);
        check_eq("arst_res", 32'(bus.res_valid_out), 32'd0);
        check_eq("arst_resdata", bus.res_data_out, 32'd0);
        check_eq("arst_accv", 32'(bus.acc_valid_out), 32'd0);
        repeat (3) tick();
        exp_ack[0] += EXP_BITS;
        exp_res[0] += 10;
        check_totals("arst");
        bus.acc_valid_in  = 1'b0;
        bus.base_valid_in = 4'h0;
        #2;
        rst_n = 1'b1;
        #1;
        check_eq("rel_accrst", 32'(bus.acc_rst_out), 32'd1);
        tick();
        check_eq("rel_accrst_low", 32'(bus.acc_rst_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
